intdiv_seq: RTL and testbench
=============================

INTDIV_SEQ -- requirements
Module: intdiv_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal values are 2 to 64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: x and y are valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept an operand pair.
REQ-006 The block SHALL have port x, input, WIDTH bits: the dividend, two's complement.
REQ-007 The block SHALL have port y, input, WIDTH bits: the divisor, two's complement.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 The block SHALL have port z, output, WIDTH bits: the quotient, two's complement.
REQ-011 The block SHALL have port r, output, WIDTH bits: the remainder, two's complement.
REQ-012 The block SHALL have port dz, output, 1 bit: divide-by-zero flag.
REQ-013 The block SHALL have port ovf, output, 1 bit: overflow flag, set only for x = most-negative value and y = -1.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, ITER, CORR and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-015 An operand pair SHALL be accepted when in_valid && in_ready; x and y SHALL be captured on that edge, and later changes to x and y SHALL be ignored.
REQ-016 When accepting with y != 0, the block SHALL go IDLE -> ITER.
REQ-017 When accepting with y == 0, the block SHALL go IDLE -> DONE, with z = all ones, r = x, dz = 1, ovf = 0.
REQ-018 ITER SHALL run exactly WIDTH cycles, producing one quotient digit per cycle, MSB first, using non-restoring recurrence.
REQ-019 Each quotient digit SHALL be in the set {-1, 0, +1}, held internally in SD2 encoding: -1 = 11, 0 = 00, +1 = 01 or 10.
REQ-020 Digit selection SHALL be +1 when the sign of the partial remainder equals the sign of y, and -1 otherwise.
REQ-021 The next partial remainder SHALL be computed as 2*PR - q_i*y, using a WIDTH+1-bit signed datapath with no loss of the sign bit.
REQ-022 After the last digit, the block SHALL go ITER -> CORR for 1 cycle.
REQ-023 CORR SHALL convert the SD2 digit vector to two's complement.
REQ-024 CORR SHALL then apply the correction step: if the final remainder is nonzero and its sign differs from the sign of x, the remainder SHALL be adjusted by +/-y and the quotient by -/+1.
REQ-025 The result SHALL truncate toward zero, and r SHALL be either zero or carry the sign of x, such that x = z*y + r.
REQ-026 For x = -2^(WIDTH-1) and y = -1, the block SHALL return z = -2^(WIDTH-1) (wrap), r = 0, ovf = 1.
REQ-027 The block SHALL go CORR -> DONE.
REQ-028 For y != 0, out_valid SHALL rise exactly WIDTH+1 cycles after the accept edge.
REQ-029 For y == 0, out_valid SHALL rise exactly 1 cycle after the accept edge.
REQ-030 In DONE, z, r, dz and ovf SHALL hold stable for as long as out_ready = 0.
REQ-031 When out_valid && out_ready, the block SHALL go DONE -> IDLE on that edge.
REQ-032 When returning to IDLE, the block SHALL NOT accept new operands in the same cycle; the next accept occurs no earlier than the following cycle.
REQ-033 A handshake SHALL never be lost: in_valid seen outside IDLE SHALL have no effect.
REQ-034 dz and ovf SHALL be valid only while out_valid = 1, and SHALL be cleared on entry to ITER.

Reset
REQ-035 When rst = 1 at a clock edge, the FSM SHALL go to IDLE in any state, including mid-ITER, CORR or DONE.
REQ-036 After reset, out_valid, z, r, dz and ovf SHALL all be 0, and in_ready SHALL be 1 in the cycle after reset deasserts.
REQ-037 A division aborted by reset SHALL produce no out_valid pulse.
REQ-038 rst SHALL take priority over in_valid and out_ready in the same cycle.

Verification
REQ-039 The bench SHALL run, with WIDTH=8: x=7, y=2 -> out_valid at accept+9; z=3, r=1, dz=0, ovf=0.
REQ-040 The bench SHALL run, with WIDTH=8: x=-7, y=2 -> z=-3 (0xFD), r=-1 (0xFF); x=100, y=-7 -> z=-14 (0xF2), r=2.
REQ-041 The bench SHALL run, with WIDTH=8: x=5, y=0 -> out_valid at accept+1; z=0xFF, r=5, dz=1, ovf=0.
REQ-042 The bench SHALL run, with WIDTH=8: x=-128, y=-1 -> z=0x80, r=0, ovf=1, dz=0.
REQ-043 The bench SHALL run, with WIDTH=8: x=-128, y=3 with out_ready held 0 for 5 cycles -> z=-42 (0xD6), r=-2 (0xFE), all outputs stable; in_valid pulses during that time are ignored; return to IDLE on the first out_ready=1 cycle.
REQ-044 The bench SHALL run: rst asserted 4 cycles into ITER -> no out_valid; in_ready=1 next cycle; the following x=9, y=3 -> z=3, r=0. The bench SHALL also run a random compare against a reference model for WIDTH=2, 8 and 16.

Source files
------------

// File: rtl/intdiv_seq.sv
// Sequential signed integer divider: non-restoring recurrence producing one SD2
// quotient digit per cycle, then a correction cycle so results truncate toward zero.
module intdiv_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] r,
  output logic             dz,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ITER = 2'd1;
  localparam logic [1:0] CORR = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  localparam logic [WIDTH-1:0] one_c = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] min_c = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]         state_r;
  logic [CW-1:0]      cnt_r;
  logic [WIDTH:0]     pr_r;
  logic [WIDTH-1:0]   xs_r;
  logic [WIDTH-1:0]   y_r;
  logic               xsign_r;
  logic [2*WIDTH-1:0] qd_r;
  logic               ovfp_r;
  logic               rdy_r;
  logic               ov_r;
  logic [WIDTH-1:0]   z_r;
  logic [WIDTH-1:0]   r_r;
  logic               dz_r;
  logic               ovf_r;

  logic [WIDTH:0]     yext_s;
  logic [WIDTH:0]     shl_s;
  logic [WIDTH:0]     pr_next_s;
  logic               sel_plus_s;
  logic [1:0]         digit_s;
  logic [WIDTH-1:0]   qpos_s;
  logic [WIDTH-1:0]   qneg_s;
  logic [WIDTH-1:0]   qraw_s;
  logic               fix_s;
  logic [WIDTH-1:0]   qfix_s;
  logic [WIDTH-1:0]   rfix_s;

  assign in_ready  = rdy_r;
  assign out_valid = ov_r;
  assign z         = z_r;
  assign r         = r_r;
  assign dz        = dz_r;
  assign ovf       = ovf_r;

  // One recurrence step: shift in the next dividend bit, then subtract or add y.
  always_comb begin
    yext_s     = {y_r[WIDTH-1], y_r};
    sel_plus_s = (pr_r[WIDTH] == y_r[WIDTH-1]);
    shl_s      = {pr_r[WIDTH-1:0], xs_r[WIDTH-1]};
    if (sel_plus_s) begin
      pr_next_s = shl_s - yext_s;
      digit_s   = 2'b01;
    end else begin
      pr_next_s = shl_s + yext_s;
      digit_s   = 2'b11;
    end
  end

  // SD2 to two's complement, then pull the remainder toward zero onto the sign of x.
  always_comb begin
    qpos_s = '0;
    qneg_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      qpos_s[i] = qd_r[2*i+1] ^ qd_r[2*i];
      qneg_s[i] = qd_r[2*i+1] & qd_r[2*i];
    end
    qraw_s = qpos_s - qneg_s;
    // A remainder of exactly +/-y is also folded into the quotient.
    fix_s = ((pr_r != '0) && (pr_r[WIDTH] != xsign_r)) ||
            (pr_r == yext_s) || (pr_r == -yext_s);
    if (!fix_s) begin
      qfix_s = qraw_s;
      rfix_s = pr_r[WIDTH-1:0];
    end else if (pr_r[WIDTH] == y_r[WIDTH-1]) begin
      qfix_s = qraw_s + one_c;
      rfix_s = pr_r[WIDTH-1:0] - y_r;
    end else begin
      qfix_s = qraw_s - one_c;
      rfix_s = pr_r[WIDTH-1:0] + y_r;
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      pr_r    <= '0;
      xs_r    <= '0;
      y_r     <= '0;
      xsign_r <= 1'b0;
      qd_r    <= '0;
      ovfp_r  <= 1'b0;
      rdy_r   <= 1'b1;
      ov_r    <= 1'b0;
      z_r     <= '0;
      r_r     <= '0;
      dz_r    <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            rdy_r   <= 1'b0;
            xs_r    <= x;
            y_r     <= y;
            xsign_r <= x[WIDTH-1];
            pr_r    <= {(WIDTH+1){x[WIDTH-1]}};
            cnt_r   <= '0;
            qd_r    <= '0;
            ovfp_r  <= (x == min_c) && (y == {WIDTH{1'b1}});
            ovf_r   <= 1'b0;
            if (y == '0) begin
              // out_valid follows one cycle later, from DONE.
              z_r     <= {WIDTH{1'b1}};
              r_r     <= x;
              dz_r    <= 1'b1;
              state_r <= DONE;
            end else begin
              dz_r    <= 1'b0;
              state_r <= ITER;
            end
          end
        end
        ITER: begin
          pr_r  <= pr_next_s;
          xs_r  <= {xs_r[WIDTH-2:0], 1'b0};
          qd_r  <= {qd_r[2*WIDTH-3:0], digit_s};
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == CW'(WIDTH-1)) begin
            state_r <= CORR;
          end
        end
        CORR: begin
          z_r     <= qfix_s;
          r_r     <= rfix_s;
          ovf_r   <= ovfp_r;
          ov_r    <= 1'b1;
          state_r <= DONE;
        end
        DONE: begin
          if (!ov_r) begin
            ov_r <= 1'b1;
          end else if (out_ready) begin
            ov_r    <= 1'b0;
            rdy_r   <= 1'b1;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          rdy_r   <= 1'b1;
          ov_r    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_intdiv_seq.sv
// Bench for intdiv_seq: WIDTH 2, 8 and 16 instances against an arithmetic
// reference model, plus directed cases with literal expectations.
module tb_intdiv_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready;
  logic [15:0] xb, yb;
  int          sel;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        chk_en = 1'b0;
  logic        seen = 1'b0;

  logic        ir2, ov2, dz2, ovf2;
  logic [1:0]  z2, r2;
  logic        ir8, ov8, dz8, ovf8;
  logic [7:0]  z8, r8;
  logic        ir16, ov16, dz16, ovf16;
  logic [15:0] z16, r16;
  logic        ir, ov, dzo, ovfo;
  logic [15:0] zo, ro;

  intdiv_seq #(.WIDTH(2)) u2 (.clk(clk), .rst(rst), .in_valid(in_valid && sel == 2), .in_ready(ir2),
    .x(xb[1:0]), .y(yb[1:0]), .out_valid(ov2), .out_ready(out_ready), .z(z2), .r(r2), .dz(dz2), .ovf(ovf2));
  intdiv_seq #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .in_valid(in_valid && sel == 8), .in_ready(ir8),
    .x(xb[7:0]), .y(yb[7:0]), .out_valid(ov8), .out_ready(out_ready), .z(z8), .r(r8), .dz(dz8), .ovf(ovf8));
  intdiv_seq #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .in_valid(in_valid && sel == 16), .in_ready(ir16),
    .x(xb), .y(yb), .out_valid(ov16), .out_ready(out_ready), .z(z16), .r(r16), .dz(dz16), .ovf(ovf16));

  always_comb begin
    case (sel)
      2:  begin ir = ir2;  ov = ov2;  zo = {14'd0, z2}; ro = {14'd0, r2}; dzo = dz2;  ovfo = ovf2;  end
      16: begin ir = ir16; ov = ov16; zo = z16;         ro = r16;         dzo = dz16; ovfo = ovf16; end
      default: begin ir = ir8; ov = ov8; zo = {8'd0, z8}; ro = {8'd0, r8}; dzo = dz8; ovfo = ovf8; end
    endcase
  end

  typedef struct {
    logic [15:0] z;
    logic [15:0] r;
    logic        dz;
    logic        ovf;
    int          acc;
    int          lat;
  } exp_t;

  exp_t exq[$];

  // Reference: plain integer division in the chosen width, results masked to w bits.
  function automatic exp_t model(input int w, input logic [15:0] xv, input logic [15:0] yv);
    exp_t   e;
    longint m, xs, ys, q, rm;
    m  = (64'sd1 <<< w) - 64'sd1;
    xs = longint'(xv) & m;
    ys = longint'(yv) & m;
    if (xs >= (64'sd1 <<< (w-1))) xs = xs - (64'sd1 <<< w);
    if (ys >= (64'sd1 <<< (w-1))) ys = ys - (64'sd1 <<< w);
    e.dz  = 1'b0;
    e.ovf = 1'b0;
    e.acc = 0;
    e.lat = w + 1;
    if (ys == 64'sd0) begin
      q = -64'sd1; rm = xs; e.dz = 1'b1; e.lat = 1;
    end else if (xs == -(64'sd1 <<< (w-1)) && ys == -64'sd1) begin
      q = xs; rm = 64'sd0; e.ovf = 1'b1;
    end else begin
      q = xs / ys; rm = xs % ys;
    end
    e.z = 16'(q & m);
    e.r = 16'(rm & m);
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process: in_ready, latency and result against the model every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      checks++;
      if (ir !== (exq.size() == 0)) begin
        errors++;
        $display("FAIL in_ready: got %b want %b at cycle %0d", ir, exq.size() == 0, cyc);
      end
      if (ov) begin
        checks++;
        if (exq.size() == 0) begin
          errors++;
          $display("FAIL spurious out_valid: got 1 want 0 at cycle %0d", cyc);
        end else begin
          e = exq[0];
          if (!seen) begin
            checks++;
            if (cyc - e.acc != e.lat) begin
              errors++;
              $display("FAIL latency: got %0d want %0d", cyc - e.acc, e.lat);
            end
            seen = 1'b1;
          end
          if (zo !== e.z || ro !== e.r || dzo !== e.dz || ovfo !== e.ovf) begin
            errors++;
            $display("FAIL result w=%0d: got z=%h r=%h dz=%b ovf=%b want z=%h r=%h dz=%b ovf=%b",
                     sel, zo, ro, dzo, ovfo, e.z, e.r, e.dz, e.ovf);
          end
          if (out_ready && !rst) begin
            void'(exq.pop_front());
            seen = 1'b0;
          end
        end
      end
      if (rst) begin
        exq.delete();
        seen = 1'b0;
      end else if (in_valid && ir) begin
        e = model(sel, xb, yb);
        e.acc = cyc + 1;
        exq.push_back(e);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, got, want);
    end
  endtask

  // Issue one operation; hold < 0 keeps out_ready high, otherwise it stays low for hold cycles.
  task automatic op(input logic [15:0] xv, input logic [15:0] yv, input int hold,
                    output logic [15:0] zc, output logic [15:0] rc,
                    output logic dzc, output logic ovfc, output int lat);
    int t;
    t = 0;
    while (!ir && t < 50) begin @(posedge clk); #1; t++; end
    xb = xv; yb = yv; in_valid = 1'b1;
    out_ready = (hold < 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    xb = 16'($urandom); yb = 16'($urandom);
    lat = 0;
    while (!ov && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++;
    if (!ov) begin
      errors++;
      $display("FAIL out_valid timeout: got 0 want 1 after %0d cycles", lat);
    end
    zc = zo; rc = ro; dzc = dzo; ovfc = ovfo;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      xb = 16'($urandom); yb = 16'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [15:0] pick(input int w);
    case ($urandom_range(0, 5))
      0: return 16'd0;
      1: return 16'd1;
      2: return 16'hFFFF;
      3: return 16'(32'd1 << (w-1));
      4: return 16'((32'd1 << (w-1)) - 32'd1);
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] zc, rc;
    logic        dzc, ovfc;
    int          lat, n, hold;
    int          widths[3];
    exp_t        em;
    widths = '{2, 8, 16};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; xb = 16'd0; yb = 16'd0; sel = 8;

    em = model(8, 16'd7, 16'd2);          chk("model 7/2 z", 32'(em.z), 32'h03);  chk("model 7/2 r", 32'(em.r), 32'h01);
    em = model(8, 16'd100, 16'hFFF9);     chk("model 100/-7 z", 32'(em.z), 32'hF2); chk("model 100/-7 r", 32'(em.r), 32'h02);
    em = model(8, 16'hFF80, 16'd3);       chk("model -128/3 z", 32'(em.z), 32'hD6); chk("model -128/3 r", 32'(em.r), 32'hFE);
    em = model(8, 16'd5, 16'd0);          chk("model 5/0 z", 32'(em.z), 32'hFF);  chk("model 5/0 dz", 32'(em.dz), 32'h1);
    em = model(2, 16'h0002, 16'h0003);    chk("model w2 ovf z", 32'(em.z), 32'h2); chk("model w2 ovf", 32'(em.ovf), 32'h1);
    em = model(16, 16'h8000, 16'd7);      chk("model w16 z", 32'(em.z), 32'hEDB7); chk("model w16 r", 32'(em.r), 32'hFFFF);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset out_valid", 32'(ov), 32'h0);
    chk("reset in_ready", 32'(ir), 32'h1);
    chk("reset z", 32'(zo), 32'h0);
    chk("reset r", 32'(ro), 32'h0);
    chk("reset dz", 32'(dzo), 32'h0);
    chk("reset ovf", 32'(ovfo), 32'h0);
    chk_en = 1'b1;

    op(16'd7, 16'd2, 0, zc, rc, dzc, ovfc, lat);
    chk("7/2 latency", 32'(lat), 32'd9); chk("7/2 z", 32'(zc), 32'h03); chk("7/2 r", 32'(rc), 32'h01);
    chk("7/2 dz", 32'(dzc), 32'h0); chk("7/2 ovf", 32'(ovfc), 32'h0);
    op(16'hFFF9, 16'd2, 1, zc, rc, dzc, ovfc, lat);
    chk("-7/2 z", 32'(zc), 32'hFD); chk("-7/2 r", 32'(rc), 32'hFF);
    op(16'd100, 16'hFFF9, -1, zc, rc, dzc, ovfc, lat);
    chk("100/-7 z", 32'(zc), 32'hF2); chk("100/-7 r", 32'(rc), 32'h02);
    op(16'd5, 16'd0, 0, zc, rc, dzc, ovfc, lat);
    chk("5/0 latency", 32'(lat), 32'd1); chk("5/0 z", 32'(zc), 32'hFF); chk("5/0 r", 32'(rc), 32'h05);
    chk("5/0 dz", 32'(dzc), 32'h1); chk("5/0 ovf", 32'(ovfc), 32'h0);
    op(16'hFF80, 16'hFFFF, 0, zc, rc, dzc, ovfc, lat);
    chk("-128/-1 z", 32'(zc), 32'h80); chk("-128/-1 r", 32'(rc), 32'h00);
    chk("-128/-1 ovf", 32'(ovfc), 32'h1); chk("-128/-1 dz", 32'(dzc), 32'h0);
    op(16'hFF80, 16'd3, 5, zc, rc, dzc, ovfc, lat);
    chk("-128/3 z", 32'(zc), 32'hD6); chk("-128/3 r", 32'(rc), 32'hFE);
    chk("idle after out_ready", 32'(ir), 32'h1);

    // Abort a division with reset four cycles into the iteration.
    xb = 16'd50; yb = 16'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort in_ready", 32'(ir), 32'h1);
    chk("abort z cleared", 32'(zo), 32'h0);
    chk("abort r cleared", 32'(ro), 32'h0);
    n = 0;
    for (int i = 0; i < 15; i++) begin
      if (ov) n++;
      @(posedge clk); #1;
    end
    chk("abort no out_valid", 32'(n), 32'h0);
    op(16'd9, 16'd3, 0, zc, rc, dzc, ovfc, lat);
    chk("9/3 z", 32'(zc), 32'h03); chk("9/3 r", 32'(rc), 32'h00);

    foreach (widths[k]) begin
      sel = widths[k];
      @(posedge clk); #1;
      repeat (150) begin
        hold = int'($urandom_range(0, 3)) - 1;
        op(pick(sel), pick(sel), hold, zc, rc, dzc, ovfc, lat);
      end
    end
    repeat (3) @(posedge clk);
    chk("queue drained", 32'(exq.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
